switch_encoder: RTL

- Inverse of the 2→4 LED decoder: a 4→2 priority encoder fed by the four Go Board switches.
- Each raw switch is synchronised and debounced. The debounced switch vector is then priority-encoded into a 2-bit code with a valid flag, a multi-press flag and a one-cycle change strobe.
- Sits between the board switch pins and downstream logic such as the decoder, 7-segment drivers or the UART TX.

---
 rtl/switch_encoder_if.sv | 21 ++
 rtl/switch_encoder.sv | 92 +++++++++
 2 files changed

// File: rtl/switch_encoder_if.sv
// Switch-to-code bundle: four raw board switches in, priority-encoded code out.
interface switch_encoder_if;
    logic       i_Switch_1;
    logic       i_Switch_2;
    logic       i_Switch_3;
    logic       i_Switch_4;
    logic [1:0] o_Code;
    logic       o_Valid;
    logic       o_Multi;
    logic       o_Strobe;

    modport master (
        output i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
        input  o_Code, o_Valid, o_Multi, o_Strobe
    );

    modport slave (
        input  i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
        output o_Code, o_Valid, o_Multi, o_Strobe
    );
endinterface

// File: rtl/switch_encoder.sv
// Synchronises and debounces four board switches, then priority-encodes the
// stable vector into a 2-bit code with valid/multi flags and a change strobe.
module switch_encoder #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    switch_encoder_if.slave sw
);
    localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

    logic [3:0]    raw;
    logic [3:0]    sync_1;
    logic [3:0]    sync_2;
    logic [3:0]    stable;
    logic [CW-1:0] cnt [4];

    logic [1:0]    code_d;
    logic          valid_d;
    logic          multi_d;
    logic [2:0]    pop;

    logic [1:0]    code_q;
    logic          valid_q;
    logic          multi_q;
    logic          strobe_q;

    assign raw = {sw.i_Switch_4, sw.i_Switch_3, sw.i_Switch_2, sw.i_Switch_1};

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Any cycle agreeing with the stable value restarts the count, so glitches
    // shorter than DEBOUNCE_LIMIT never reach the encoder.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            stable <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync_2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        code_d  = 2'b00;
        valid_d = |stable;
        if (stable[3])      code_d = 2'b11;
        else if (stable[2]) code_d = 2'b10;
        else if (stable[1]) code_d = 2'b01;
        pop     = {2'b00, stable[0]} + {2'b00, stable[1]}
                + {2'b00, stable[2]} + {2'b00, stable[3]};
        multi_d = (pop >= 3'd2);
    end

    // Strobe lands in the same cycle the registered code/valid change; multi
    // alone is deliberately excluded.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            code_q   <= 2'b00;
            valid_q  <= 1'b0;
            multi_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            code_q   <= code_d;
            valid_q  <= valid_d;
            multi_q  <= multi_d;
            strobe_q <= ({valid_d, code_d} != {valid_q, code_q});
        end
    end

    assign sw.o_Code   = code_q;
    assign sw.o_Valid  = valid_q;
    assign sw.o_Multi  = multi_q;
    assign sw.o_Strobe = strobe_q;
endmodule
